// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Imported by the interface, the top level and the per-bit datapath.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of an addition, from the carries into and out of the MSB.
    function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The producer/consumer side uses master, the adder uses slave.
interface serial_adder_if #(
    parameter int WIDTH = serial_adder_pkg::SERIAL_ADDER_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit datapath of the serial adder: a full adder built from two half adders.
// The OR of the two partial carries cannot see both set at once.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s_ab;
    logic c_ab;
    logic c_sc;

    half_adder u_ha_ab (
        .a (a),
        .b (b),
        .s (s_ab),
        .c (c_ab)
    );

    half_adder u_ha_sc (
        .a (s_ab),
        .b (cin),
        .s (s),
        .c (c_sc)
    );

    assign cout = c_ab | c_sc;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder, one result bit per clock, valid/ready on both sides.
// Build option SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b (cin ignored).
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand pair; last result held
//   RUN   | one bit per edge, WIDTH edges
//   DONE  | out_valid=1, result held until out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic              sub,
`endif
    serial_adder_if.slave     bus
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             do_sub;
    logic             fa_s;
    logic             fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    assign do_sub = sub;
`else
    assign do_sub = 1'b0;
`endif

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is a + ~b + 1: invert B once at acceptance, force carry-in.
                    a_d     = bus.a;
                    b_d     = do_sub ? ~bus.b : bus.b;
                    carry_d = do_sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB
                    cout_d  = fa_co;
                    ovf_d   = signed_ovf(carry_q, fa_co);
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit vectors, backpressure, mid-run reset,
// optional subtraction, and a 4-bit exhaustive sweep with random out_ready.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    logic sub8;
    logic sub4;

    int vectors;
    int miscompares;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(4)) if4 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .bus   (if8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub4),
`endif
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation: accept, measure latency, check result, optionally stall in DONE,
    // optionally wave in_valid with junk operands while busy.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic [7:0] esum, input logic ecout, input logic eovf,
                       input int stall, input bit noise);
        int n;
        chk({tag, ":in_ready"}, 64'(if8.in_ready), 64'd1);
        if8.out_ready = (stall == 0);
        if8.a = av; if8.b = bv; if8.cin = ci; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if (noise) begin
            if8.a = ~av; if8.b = 8'h5A; if8.cin = ~ci;
        end else begin
            if8.in_valid = 1'b0;
        end
        n = 0;
        while (!if8.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if8.in_valid = 1'b0;
        chk({tag, ":latency"}, 64'(n), 64'd8);
        chk({tag, ":sum"},  64'(if8.sum),  64'(esum));
        chk({tag, ":cout"}, 64'(if8.cout), 64'(ecout));
        chk({tag, ":ovf"},  64'(if8.ovf),  64'(eovf));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ":hold"}, {54'd0, if8.out_valid, if8.in_ready, if8.sum}, {54'd0, 1'b1, 1'b0, esum});
        end
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ":to_idle"}, {62'd0, if8.in_ready, if8.out_valid}, {62'd0, 1'b1, 1'b0});
    endtask

    initial begin
        int n;
        int seen;
        logic [4:0] full;
        logic       e_ovf;
        vectors = 0;
        miscompares = 0;
        sub8 = 1'b0;
        sub4 = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset:in_ready",  64'(if8.in_ready),  64'd1);
        chk("reset:out_valid", 64'(if8.out_valid), 64'd0);
        chk("reset:sum",       64'(if8.sum),       64'd0);
        chk("reset:cout_ovf",  {62'd0, if8.cout, if8.ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8("0f+01",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, 1'b0);
        op8("ff+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        op8("7f+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
        op8("80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        op8("55+aa+1", 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        op8("10+20+1", 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 0, 1'b1);
        op8("stall5",  8'h3C, 8'h21, 1'b0, 8'h5D, 1'b0, 1'b0, 5, 1'b0);

        chk("idle_hold:sum", 64'(if8.sum), 64'h5D);

        // Reset in the middle of RUN: no result may appear afterwards.
        if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst:async", {61'd0, if8.out_valid, if8.in_ready, |if8.sum}, {61'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (if8.out_valid || !if8.in_ready) seen++;
        end
        chk("midrst:quiet", 64'(seen), 64'd0);
        op8("03+04", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b1;
        op8("05-07", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 0, 1'b0);
        op8("07-05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, 0, 1'b0);
        sub8 = 1'b0;
`endif

        // 4-bit exhaustive sweep against integer arithmetic.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int c = 0; c < 2; c++) begin
                    full  = 5'(av) + 5'(bv) + 5'(c);
                    e_ovf = (av[3] == bv[3]) && (full[3] != av[3]);
                    if4.out_ready = 1'b0;
                    if4.a = 4'(av); if4.b = 4'(bv); if4.cin = c[0]; if4.in_valid = 1'b1;
                    @(posedge clk); #1;
                    if4.in_valid = 1'b0;
                    n = 0;
                    while (!if4.out_valid && n < 20) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    chk("w4:result", {57'd0, n == 4, if4.cout, if4.ovf, if4.sum},
                                     {57'd0, 1'b1, full[4], e_ovf, full[3:0]});
                    n = 0;
                    do begin
                        if4.out_ready = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                        n++;
                    end while (if4.out_valid && n < 20);
                    if (n >= 20) chk("w4:handshake_timeout", 64'(n), 64'd0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operands.
REQ-006 SHALL have port a  input  WIDTH  addend A, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  addend B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  WIDTH  result bits.
REQ-012 SHALL have port cout  output  1  carry-out of MSB.
REQ-013 SHALL have port ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE, bit-serial LSB-first, one result bit per clock.
REQ-015 IDLE: in_ready=1; in_valid=1 at an edge is an acceptance: latch a, b into shift registers, carry flop <= cin, bit counter <= 0, go RUN.
REQ-016 RUN: in_ready=0; each edge adds LSBs of both shift registers plus carry flop, shifts the sum bit into sum register MSB end, updates carry, increments counter.
REQ-017 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge capture carry into cout, compute ovf from carry into and out of bit WIDTH-1, go DONE.
REQ-018 out_valid SHALL rise exactly WIDTH clock edges after the acceptance edge.
REQ-019 DONE: out_valid=1, in_ready=0; sum, cout, ovf stable until the edge where out_ready=1, then IDLE.
REQ-020 out_valid SHALL never drop without a handshake; in_valid during RUN/DONE SHALL be ignored.
REQ-021 sum/cout/ovf SHALL hold last result while in IDLE; values outside DONE carry no meaning.
REQ-022 Throughput: at most one operation per WIDTH+2 cycles; no overlap of operations.
REQ-023 Bit counter width SHALL be $clog2(WIDTH+1); no wrap within legal WIDTH.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, sum=0, cout=0, ovf=0, carry flop=0, counter=0.
REQ-025 Reset asserted during RUN or DONE SHALL discard the in-flight operation; no result emitted after release.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN defined: extra port sub  input  1, sampled at acceptance; sub=1 computes a - b - (~cin... ) defined as a + ~b + 1 with cin ignored; cout=1 means no borrow.
REQ-027 Macro undefined: no sub port; addition only.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 One sub-module full_adder (a, b, cin -> s, cout), built from two half_adder instances plus OR, SHALL form the per-bit datapath.

Verification
REQ-030 WIDTH=8, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, ovf=0, out_valid 8 edges after acceptance.
REQ-031 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-032 Backpressure: out_ready low 5 cycles in DONE -> out_valid and sum held unchanged, in_ready=0 throughout; release -> IDLE next edge.
REQ-033 rst_n pulsed low at RUN bit 3 -> out_valid stays 0, in_ready=1 after release; next op 0x03+0x04 -> 0x07.
REQ-034 SERIAL_ADDER_SUB_EN, sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-035 WIDTH=4 exhaustive a, b, cin (512 ops) with random out_ready -> sum/cout/ovf match arithmetic model.
